// File: rtl/memrsp_pkg.sv
// Shared types and helpers for the memory responder / store checker.
package memrsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Expected store. Only the word address is kept; byte offsets never take part in matching.
  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
  } chk_entry_t;

  // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // True when every byte lane enabled in wstrb holds the same value in a and b.
  function automatic logic bytes_equal(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [3:0]  wstrb);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i] && (a[8*i +: 8] != b[8*i +: 8])) eq = 1'b0;
    end
    return eq;
  endfunction

endpackage

// File: rtl/memrsp_scoreboard.sv
// Store scoreboard: table of expected {addr,data} entries, lowest-index match,
// per-entry hit flags and saturating pass/fail/unexpected/out-of-range counters.
module memrsp_scoreboard
  import memrsp_pkg::*;
#(
  parameter int NUM_CHECKS = 16,
  parameter int CNT_W      = 16,
  parameter int IW         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_we,
  input  logic [IW-1:0]    chk_idx,
  input  logic             chk_valid,
  input  logic [31:0]      chk_addr,
  input  logic [31:0]      chk_data,
  input  logic             st_en,
  input  logic [29:0]      st_waddr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_wstrb,
  input  logic             oob_en,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] unexp_cnt,
  output logic [CNT_W-1:0] oob_cnt,
  output logic             all_hit
);

  chk_entry_t               entry_q [NUM_CHECKS];
  logic [NUM_CHECKS-1:0]    hit_q, hit_d, valid_vec;
  logic                     match_found, match_eq;
  logic [IW-1:0]            match_idx;
  logic [CNT_W-1:0]         pass_q, fail_q, unexp_q, oob_q;
  logic                     unused_chk_lsbs;

  assign unused_chk_lsbs = ^chk_addr[1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Table write; entries survive reset so a bench can reset without reprogramming.
  always_ff @(posedge clk) begin
    if (chk_we) entry_q[chk_idx] <= '{valid: chk_valid, addr: chk_addr[31:2], data: chk_data};
  end

  // Priority match: scan downwards so the lowest matching index is the one kept.
  always_comb begin
    match_found = 1'b0;
    match_eq    = 1'b0;
    match_idx   = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (entry_q[i].valid && (entry_q[i].addr == st_waddr)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
        match_eq    = bytes_equal(entry_q[i].data, st_data, st_wstrb);
      end
    end
  end

  // Hit flags: a rewrite of an entry clears its flag even if it passed this cycle.
  always_comb begin
    hit_d = hit_q;
    if (st_en && match_found && match_eq) hit_d[match_idx] = 1'b1;
    if (chk_we) hit_d[chk_idx] = 1'b0;
  end

  // Gather entry valid bits for the all-hit reduction.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_CHECKS; i++) valid_vec[i] = entry_q[i].valid;
  end

  // Hit flags and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      unexp_q <= '0;
      oob_q   <= '0;
    end else begin
      hit_q <= hit_d;
      if (st_en) begin
        if (!match_found)  unexp_q <= sat_inc(unexp_q);
        else if (match_eq) pass_q  <= sat_inc(pass_q);
        else               fail_q  <= sat_inc(fail_q);
      end
      if (oob_en) oob_q <= sat_inc(oob_q);
    end
  end

  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign unexp_cnt = unexp_q;
  assign oob_cnt   = oob_q;
  assign all_hit   = (|valid_vec) && (&(hit_q | ~valid_vec));

endmodule

// File: rtl/mem_responder_checker.sv
// picorv32 native-bus memory responder with a store scoreboard.
// Optional feature: define MEMRSP_RANDWAIT_EN to draw each wait count from an LFSR
// (lfsr[3:0] % (WAIT_CYCLES+1)) instead of using the fixed WAIT_CYCLES.
//
// state | meaning
// IDLE  | waiting for mem_valid; not sampled while mem_ready is still high
// WAIT  | burning the wait count latched at accept
// RESP  | RAM read/write and scoreboard update; mem_ready rises on the following edge
module mem_responder_checker
  import memrsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int NUM_CHECKS  = 16,
  parameter int CNT_W       = 16
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               mem_valid,
  input  logic                                               mem_instr,
  input  logic [31:0]                                        mem_addr,
  input  logic [31:0]                                        mem_wdata,
  input  logic [3:0]                                         mem_wstrb,
  output logic                                               mem_ready,
  output logic [31:0]                                        mem_rdata,
  input  logic                                               ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0]                     ld_addr,
  input  logic [31:0]                                        ld_data,
  input  logic                                               chk_we,
  input  logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] chk_idx,
  input  logic                                               chk_valid,
  input  logic [31:0]                                        chk_addr,
  input  logic [31:0]                                        chk_data,
  output logic [CNT_W-1:0]                                   pass_cnt,
  output logic [CNT_W-1:0]                                   fail_cnt,
  output logic [CNT_W-1:0]                                   unexp_cnt,
  output logic [CNT_W-1:0]                                   oob_cnt,
  output logic                                               all_hit
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   ram [DEPTH_WORDS];

  logic          accept;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [3:0]    wait_cnt;
  logic          ram_we, ld_ok;
  logic          st_en, oob_en;
  logic          unused_sig;

  // mem_instr only labels the access for tracing; byte offset bits never select a word.
  assign unused_sig = ^{mem_instr, addr_q[1:0]};

  assign word_idx = addr_q[AW+1:2];
  assign in_range = (addr_q[31:AW+2] == '0);
  assign accept   = (state_q == IDLE) && mem_valid && !ready_q;

`ifdef MEMRSP_RANDWAIT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR steps once per accepted request.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign wait_cnt = 4'({28'd0, lfsr_q[3:0]} % (WAIT_CYCLES + 1));
`else
  assign wait_cnt = WAIT_INIT;
`endif

  // Next-state and response logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wcnt_d  = wcnt_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          wcnt_d  = wait_cnt;
          state_d = (wait_cnt == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q <= 4'd1) state_d = RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      RESP: begin
        ready_d = 1'b1;
        rdata_d = in_range ? ram[word_idx] : 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and bus output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // A reset landing on the RESP edge must drop the store completely.
  assign ram_we = (state_q == RESP) && !reset && in_range && (wstrb_q != 4'h0);
  assign ld_ok  = ld_we && !(ram_we && (ld_addr == word_idx));
  assign st_en  = (state_q == RESP) && !reset && (wstrb_q != 4'h0);
  assign oob_en = (state_q == RESP) && !reset && !in_range;

  // RAM: preload port plus byte-lane bus stores; the bus store owns a colliding word.
  always_ff @(posedge clk) begin
    if (ld_ok) ram[ld_addr] <= ld_data;
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) ram[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  memrsp_scoreboard #(
    .NUM_CHECKS (NUM_CHECKS),
    .CNT_W      (CNT_W),
    .IW         (IW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .chk_we    (chk_we),
    .chk_idx   (chk_idx),
    .chk_valid (chk_valid),
    .chk_addr  (chk_addr),
    .chk_data  (chk_data),
    .st_en     (st_en),
    .st_waddr  (addr_q[31:2]),
    .st_data   (wdata_q),
    .st_wstrb  (wstrb_q),
    .oob_en    (oob_en),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .unexp_cnt (unexp_cnt),
    .oob_cnt   (oob_cnt),
    .all_hit   (all_hit)
  );

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule
